// File: rtl/servo_output_limiter.sv
// Clamp stage and rail-contact supervisor between the anti-windup IIR filter and the DAC.
// Optional build macro: SERVO_LIMITER_AUTO_RELOCK_EN (UNLOCKED returns to TRACK after a holdoff).
module servo_output_limiter #(
    parameter int IN_SIZE   = 18,
    parameter int OUT_SIZE  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 on_in,
    input  logic [IN_SIZE-1:0]   signal_in,
    input  logic [OUT_SIZE-1:0]  min_in,
    input  logic [OUT_SIZE-1:0]  max_in,
    input  logic [CNT_WIDTH-1:0] rail_timeout_in,
    input  logic                 clear_in,
    output logic [OUT_SIZE-1:0]  signal_out,
    output logic [1:0]           railed_out,
    output logic                 hold_out,
    output logic                 lock_lost_out,
    output logic [CNT_WIDTH-1:0] rail_count_out
);

    typedef enum logic [1:0] {
        OFF,
        TRACK,
        RAILED,
        UNLOCKED
    } state_t;

    state_t state, state_next;

    logic signed [IN_SIZE-1:0] x_val;
    logic signed [IN_SIZE-1:0] min_ext;
    logic signed [IN_SIZE-1:0] max_ext;
    logic                      lo;
    logic                      hi;
    logic [OUT_SIZE-1:0]       clamped;
    logic [CNT_WIDTH-1:0]      count_inc;
    logic                      timeout_hit;

    logic [CNT_WIDTH-1:0]      count_next;
    logic [1:0]                railed_next;
    logic                      hold_next;
    logic                      lock_next;
    logic                      unlock_evt;

    // Rails are widened into the guard-banded domain so out-of-range inputs cannot wrap.
    assign x_val   = signal_in;
    assign min_ext = {{(IN_SIZE-OUT_SIZE){min_in[OUT_SIZE-1]}}, min_in};
    assign max_ext = {{(IN_SIZE-OUT_SIZE){max_in[OUT_SIZE-1]}}, max_in};

    assign lo      = (x_val < min_ext);
    assign hi      = !lo && (x_val > max_ext);
    assign clamped = lo ? min_in : (hi ? max_in : signal_in[OUT_SIZE-1:0]);

    assign count_inc   = (rail_count_out == {CNT_WIDTH{1'b1}}) ? rail_count_out
                                                               : rail_count_out + CNT_WIDTH'(1);
    assign timeout_hit = (rail_timeout_in != '0) && (count_inc >= rail_timeout_in);

    always_comb begin
        state_next  = state;
        count_next  = rail_count_out;
        railed_next = 2'b00;
        hold_next   = 1'b0;
        lock_next   = lock_lost_out;
        unlock_evt  = 1'b0;

        if (!on_in) begin
            state_next = OFF;
            count_next = '0;
        end else begin
            case (state)
                OFF: begin
                    state_next = TRACK;
                    count_next = '0;
                end
                TRACK: begin
                    railed_next = {hi, lo};
                    if (lo || hi) begin
                        state_next = RAILED;
                        count_next = CNT_WIDTH'(1);
                    end else begin
                        count_next = '0;
                    end
                end
                RAILED: begin
                    railed_next = {hi, lo};
                    if (lo || hi) begin
                        if (timeout_hit) begin
                            state_next = UNLOCKED;
                            count_next = '0;
                            unlock_evt = 1'b1;
                        end else begin
                            count_next = count_inc;
                        end
                    end else begin
                        state_next = TRACK;
                        count_next = '0;
                    end
                end
                UNLOCKED: begin
                    railed_next = {hi, lo};
                    if (clear_in) begin
                        state_next = TRACK;
                        count_next = '0;
`ifdef SERVO_LIMITER_AUTO_RELOCK_EN
                    end else if (timeout_hit) begin
                        state_next = TRACK;
                        count_next = '0;
`endif
                    end else begin
                        hold_next  = 1'b1;
                        count_next = count_inc;
                    end
                end
                default: begin
                    state_next = OFF;
                    count_next = '0;
                end
            endcase
        end

        // A timeout in the same cycle as a clear must leave the fault flagged.
        if (unlock_evt) begin
            lock_next = 1'b1;
        end else if (clear_in) begin
            lock_next = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= OFF;
            signal_out     <= '0;
            railed_out     <= 2'b00;
            hold_out       <= 1'b0;
            lock_lost_out  <= 1'b0;
            rail_count_out <= '0;
        end else begin
            state          <= state_next;
            signal_out     <= clamped;
            railed_out     <= railed_next;
            hold_out       <= hold_next;
            lock_lost_out  <= lock_next;
            rail_count_out <= count_next;
        end
    end

endmodule

// File: tb/tb_servo_output_limiter.sv
// Scoreboard bench for servo_output_limiter: directed vectors push expected outputs, a monitor pops and compares.
module tb_servo_output_limiter;

    localparam int IN_SIZE   = 18;
    localparam int OUT_SIZE  = 16;
    localparam int CNT_WIDTH = 16;

    localparam logic [4:0] M_SIG  = 5'b00001;
    localparam logic [4:0] M_RAIL = 5'b00010;
    localparam logic [4:0] M_HOLD = 5'b00100;
    localparam logic [4:0] M_LOCK = 5'b01000;
    localparam logic [4:0] M_CNT  = 5'b10000;
    localparam logic [4:0] M_ALL  = 5'b11111;

    logic                 clk_in;
    logic                 rst_in;
    logic                 on_in;
    logic [IN_SIZE-1:0]   signal_in;
    logic [OUT_SIZE-1:0]  min_in;
    logic [OUT_SIZE-1:0]  max_in;
    logic [CNT_WIDTH-1:0] rail_timeout_in;
    logic                 clear_in;
    logic [OUT_SIZE-1:0]  signal_out;
    logic [1:0]           railed_out;
    logic                 hold_out;
    logic                 lock_lost_out;
    logic [CNT_WIDTH-1:0] rail_count_out;

    typedef struct {
        logic [4:0]  mask;
        logic [15:0] sig;
        logic [1:0]  rail;
        logic        hold;
        logic        lock;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    servo_output_limiter #(
        .IN_SIZE  (IN_SIZE),
        .OUT_SIZE (OUT_SIZE),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .on_in          (on_in),
        .signal_in      (signal_in),
        .min_in         (min_in),
        .max_in         (max_in),
        .rail_timeout_in(rail_timeout_in),
        .clear_in       (clear_in),
        .signal_out     (signal_out),
        .railed_out     (railed_out),
        .hold_out       (hold_out),
        .lock_lost_out  (lock_lost_out),
        .rail_count_out (rail_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic exp_t ex(input logic [4:0] m, input int s, input logic [1:0] r,
                                input logic h, input logic l, input int c);
        exp_t e;
        e.mask = m;
        e.sig  = s[15:0];
        e.rail = r;
        e.hold = h;
        e.lock = l;
        e.cnt  = c[15:0];
        return e;
    endfunction

    // Inputs change on the falling edge; the matching expectation is queued at the same time.
    task automatic apply_stimulus(input int sig, input logic clr, input exp_t e);
        signal_in = sig[IN_SIZE-1:0];
        clear_in  = clr;
        sb_q.push_back(e);
        @(negedge clk_in);
    endtask

    task automatic check_field(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: actual %0d required %0d", name, $time, act, req);
        end
    endtask

    task automatic check_output(input exp_t e);
        if (e.mask & M_SIG)  check_field("signal_out", int'($signed(signal_out)), int'($signed(e.sig)));
        if (e.mask & M_RAIL) check_field("railed_out", int'(railed_out), int'(e.rail));
        if (e.mask & M_HOLD) check_field("hold_out", int'(hold_out), int'(e.hold));
        if (e.mask & M_LOCK) check_field("lock_lost_out", int'(lock_lost_out), int'(e.lock));
        if (e.mask & M_CNT)  check_field("rail_count_out", int'(rail_count_out), int'(e.cnt));
    endtask

    // Monitor: each rising edge presents the registered response to the previous vector.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (sb_q.size() > 0) begin
                check_output(sb_q.pop_front());
            end
        end
    end

    initial begin
        rst_in          = 1'b1;
        on_in           = 1'b0;
        clear_in        = 1'b0;
        signal_in       = '0;
        min_in          = -16'sd1000;
        max_in          = 16'sd1000;
        rail_timeout_in = '0;
        @(negedge clk_in);

        apply_stimulus(500, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));
        apply_stimulus(500, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));
        rst_in = 1'b0;
        on_in  = 1'b1;

        // Basic clamping
        apply_stimulus(500, 0, ex(M_ALL, 500, 2'b00, 0, 0, 0));
        apply_stimulus(500, 0, ex(M_ALL, 500, 2'b00, 0, 0, 0));
        apply_stimulus(1200, 0, ex(M_ALL, 1000, 2'b10, 0, 0, 1));
        apply_stimulus(-1001, 0, ex(M_ALL, -1000, 2'b01, 0, 0, 2));
        apply_stimulus(1000, 0, ex(M_ALL, 1000, 2'b00, 0, 0, 0));
        apply_stimulus(-1000, 0, ex(M_ALL, -1000, 2'b00, 0, 0, 0));

        // Guard-bit extremes must saturate, not wrap
        max_in = 16'sd32767;
        apply_stimulus(131071, 0, ex(M_ALL, 32767, 2'b10, 0, 0, 1));
        min_in = -16'sd32768;
        apply_stimulus(-131072, 0, ex(M_ALL, -32768, 2'b01, 0, 0, 2));
        min_in = -16'sd1000;
        max_in = 16'sd1000;
        apply_stimulus(0, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));

        // Swapped rails: lower rail takes priority
        min_in = 16'sd100;
        max_in = -16'sd100;
        apply_stimulus(0, 0, ex(M_ALL, 100, 2'b01, 0, 0, 1));
        apply_stimulus(-200, 0, ex(M_ALL, 100, 2'b01, 0, 0, 2));
        apply_stimulus(200, 0, ex(M_ALL, -100, 2'b10, 0, 0, 3));
        min_in = -16'sd1000;
        max_in = 16'sd1000;
        apply_stimulus(0, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));

        // Timeout of 5 railed cycles, then clear
        rail_timeout_in = 16'd5;
        for (int k = 1; k <= 4; k++) apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 0, k));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 1, 0));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 1, 1, 1));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 1, 1, 2));
        apply_stimulus(0, 1, ex(M_ALL, 0, 2'b00, 0, 0, 0));
        apply_stimulus(0, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));

        // Interrupted contact never reaches the timeout
        for (int k = 1; k <= 4; k++) apply_stimulus(-2000, 0, ex(M_ALL, -1000, 2'b01, 0, 0, k));
        apply_stimulus(0, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));
        for (int k = 1; k <= 4; k++) apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 0, k));
        apply_stimulus(0, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));

        // Timeout of 1 with a clear arriving together with the timeout
        rail_timeout_in = 16'd1;
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 0, 1));
        apply_stimulus(2000, 1, ex(M_ALL, 1000, 2'b10, 0, 1, 0));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 1, 1, 1));
        apply_stimulus(0, 1, ex(M_ALL, 0, 2'b00, 0, 0, 0));

        // Timeout raised from 0 to 3 while already railed
        rail_timeout_in = 16'd0;
        for (int k = 1; k <= 3; k++) apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 0, k));
        rail_timeout_in = 16'd3;
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 1, 0));
        apply_stimulus(0, 1, ex(M_ALL, 0, 2'b00, 0, 0, 0));

        // Long contact with timeout disabled: counter saturates
        rail_timeout_in = 16'd0;
        for (int k = 1; k <= 70000; k++) begin
            if (k == 65534 || k == 65535 || k == 65536)
                apply_stimulus(2000, 0, ex(M_CNT, 0, 2'b00, 0, 0, (k > 65535) ? 65535 : k));
            else if (k == 70000)
                apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 0, 65535));
            else
                apply_stimulus(2000, 0, ex(5'b00000, 0, 2'b00, 0, 0, 0));
        end

        // Servo disabled: still clamped, railed and count forced low
        on_in = 1'b0;
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b00, 0, 0, 0));
        apply_stimulus(-5000, 0, ex(M_ALL, -1000, 2'b00, 0, 0, 0));

        // Sticky flag survives OFF and is cleared there by clear_in
        on_in = 1'b1;
        apply_stimulus(0, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));
        rail_timeout_in = 16'd2;
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 0, 1));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 1, 0));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 1, 1, 1));
        on_in = 1'b0;
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b00, 0, 1, 0));
        apply_stimulus(0, 1, ex(M_ALL, 0, 2'b00, 0, 0, 0));

        // Reset while UNLOCKED with hold asserted
        on_in = 1'b1;
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b00, 0, 0, 0));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 0, 1));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 0, 1, 0));
        apply_stimulus(2000, 0, ex(M_ALL, 1000, 2'b10, 1, 1, 1));
        rst_in = 1'b1;
        apply_stimulus(2000, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));
        rst_in = 1'b0;
        apply_stimulus(0, 0, ex(M_ALL, 0, 2'b00, 0, 0, 0));

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk_in);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: actual %0d pending entries required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
